// File: rtl/dmem_pkg.sv
`timescale 1ns/1ps
// Shared types and helpers for the doubleword data-memory responder.
package dmem_pkg;
   typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

   localparam int DW_BYTES = 8;
   localparam int DW_SHIFT = 3;

   // Misaligned, or any address bit set above the storage span.
   function automatic logic addr_err(input logic [63:0] addr, input int addr_bits);
      logic [63:0] hi_mask;
      hi_mask = ~((64'd1 << (addr_bits + DW_SHIFT)) - 64'd1);
      return ((addr & 64'(DW_BYTES - 1)) != 64'd0) || ((addr & hi_mask) != 64'd0);
   endfunction
endpackage

// File: rtl/dmem_responder_if.sv
`timescale 1ns/1ps
// Request/response channels between the core's data port and the responder.
interface dmem_responder_if;
   logic        req_valid;
   logic        req_ready;
   logic        req_write;
   logic [63:0] req_addr;
   logic [63:0] req_wdata;
   logic        rsp_valid;
   logic        rsp_ready;
   logic [63:0] rsp_rdata;
   logic        rsp_err;

   modport master (
      output req_valid, req_write, req_addr, req_wdata, rsp_ready,
      input  req_ready, rsp_valid, rsp_rdata, rsp_err
   );

   modport slave (
      input  req_valid, req_write, req_addr, req_wdata, rsp_ready,
      output req_ready, rsp_valid, rsp_rdata, rsp_err
   );
endinterface

// File: rtl/dmem_array.sv
`timescale 1ns/1ps
// 2^ADDR_BITS x 64 storage: synchronous write, combinational read.
// Contents are deliberately never reset.
module dmem_array #(
   parameter int ADDR_BITS = 8
) (
   input  logic                 CLK,
   input  logic                 we,
   input  logic [ADDR_BITS-1:0] widx,
   input  logic [63:0]          wdata,
   input  logic [ADDR_BITS-1:0] ridx,
   output logic [63:0]          rdata
);
   logic [63:0] mem [2**ADDR_BITS];

   always_ff @(posedge CLK) begin
      if (we) mem[widx] <= wdata;
   end

   assign rdata = mem[ridx];
endmodule

// File: rtl/dmem_responder.sv
`timescale 1ns/1ps
// Doubleword load/store responder, one request outstanding, LATENCY cycles request to response.
// rsp_ready low holds RESP (and its data) indefinitely; req_ready stays low until the response is taken.
module dmem_responder #(
   parameter int ADDR_BITS = 8,
   parameter int LATENCY   = 3
) (
   input  logic               CLK,
   input  logic               Reset_L,
   dmem_responder_if.slave    bus
);
   import dmem_pkg::*;

   localparam logic [3:0] LAT_M1 = 4'(LATENCY - 1);

   state_t      state;
   logic [3:0]  cnt;
   logic        wr_q;
   logic [63:0] addr_q;
   logic [63:0] wdata_q;
   logic        req_ready_q;
   logic        rsp_valid_q;
   logic [63:0] rsp_rdata_q;
   logic        rsp_err_q;

   logic        acc_fire;
   logic        acc_write;
   logic        acc_err;
   logic [63:0] acc_addr;
   logic [63:0] acc_wdata;
   logic [63:0] mem_rdata;

   // With LATENCY=1 the access happens on the accepting edge, straight from the bus.
   always_comb begin
      acc_fire  = 1'b0;
      acc_write = wr_q;
      acc_addr  = addr_q;
      acc_wdata = wdata_q;
      if (state == IDLE) begin
         acc_write = bus.req_write;
         acc_addr  = bus.req_addr;
         acc_wdata = bus.req_wdata;
         acc_fire  = bus.req_valid && req_ready_q && (LATENCY == 1);
      end else if (state == BUSY) begin
         acc_fire  = (cnt == 4'd1);
      end
      acc_err = addr_err(acc_addr, ADDR_BITS);
   end

   dmem_array #(.ADDR_BITS(ADDR_BITS)) u_array (
      .CLK   (CLK),
      .we    (acc_fire && acc_write && !acc_err),
      .widx  (acc_addr[ADDR_BITS+2:3]),
      .wdata (acc_wdata),
      .ridx  (acc_addr[ADDR_BITS+2:3]),
      .rdata (mem_rdata)
   );

   always_ff @(posedge CLK or negedge Reset_L) begin
      if (!Reset_L) begin
         state       <= IDLE;
         cnt         <= 4'd0;
         wr_q        <= 1'b0;
         addr_q      <= 64'd0;
         wdata_q     <= 64'd0;
         req_ready_q <= 1'b0;
         rsp_valid_q <= 1'b0;
         rsp_rdata_q <= 64'd0;
         rsp_err_q   <= 1'b0;
      end else begin
         if (acc_fire) begin
            rsp_valid_q <= 1'b1;
            rsp_err_q   <= acc_err;
            rsp_rdata_q <= (acc_write || acc_err) ? 64'd0 : mem_rdata;
         end
         case (state)
            IDLE: begin
               req_ready_q <= 1'b1;
               if (bus.req_valid && req_ready_q) begin
                  wr_q        <= bus.req_write;
                  addr_q      <= bus.req_addr;
                  wdata_q     <= bus.req_wdata;
                  cnt         <= LAT_M1;
                  req_ready_q <= 1'b0;
                  state       <= (LATENCY == 1) ? RESP : BUSY;
               end
            end
            BUSY: begin
               cnt <= cnt - 4'd1;
               if (cnt == 4'd1) state <= RESP;
            end
            RESP: begin
               if (bus.rsp_ready) begin
                  rsp_valid_q <= 1'b0;
                  rsp_rdata_q <= 64'd0;
                  rsp_err_q   <= 1'b0;
                  req_ready_q <= 1'b1;
                  state       <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign bus.req_ready = req_ready_q;
   assign bus.rsp_valid = rsp_valid_q;
   assign bus.rsp_rdata = rsp_rdata_q;
   assign bus.rsp_err   = rsp_err_q;
endmodule

// File: tb/tb_dmem_responder.sv
`timescale 1ns/1ps
// Bench for dmem_responder: LATENCY=3 instance (directed table, backpressure, reset, random)
// and LATENCY=1 instance (back-to-back loads).
module tb_dmem_responder;
   logic CLK;
   logic rst_a;
   logic rst_b;

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   dmem_responder_if bus_a();
   dmem_responder_if bus_b();

   dmem_responder #(.ADDR_BITS(8), .LATENCY(3)) dut  (.CLK(CLK), .Reset_L(rst_a), .bus(bus_a));
   dmem_responder #(.ADDR_BITS(8), .LATENCY(1)) dut1 (.CLK(CLK), .Reset_L(rst_b), .bus(bus_b));

   int checks   = 0;
   int failures = 0;

   logic [63:0] ref_mem [256];
   logic [63:0] bvals [4];

   typedef struct {
      logic        w;
      logic [63:0] addr;
      logic [63:0] wdata;
      logic        err;
      logic [63:0] rdata;
   } vec_t;

   vec_t vt [11];

   // Reference: byte-addressed doubleword memory of 256 entries, no wrap.
   function automatic void model_access(input logic w, input logic [63:0] a, input logic [63:0] d,
                                        output logic e, output logic [63:0] r);
      e = ((a % 64'd8) != 64'd0) || (a >= 64'd2048);
      r = 64'd0;
      if (!e) begin
         if (w) ref_mem[int'(a / 64'd8)] = d;
         else   r = ref_mem[int'(a / 64'd8)];
      end
   endfunction

   function automatic logic rd_ready(input bit s);
      return s ? bus_b.req_ready : bus_a.req_ready;
   endfunction
   function automatic logic rd_rvalid(input bit s);
      return s ? bus_b.rsp_valid : bus_a.rsp_valid;
   endfunction
   function automatic logic [63:0] rd_rdata(input bit s);
      return s ? bus_b.rsp_rdata : bus_a.rsp_rdata;
   endfunction
   function automatic logic rd_err(input bit s);
      return s ? bus_b.rsp_err : bus_a.rsp_err;
   endfunction

   task automatic drv(input bit s, input logic v, input logic w, input logic [63:0] a, input logic [63:0] d);
      if (s) begin
         bus_b.req_valid = v; bus_b.req_write = w; bus_b.req_addr = a; bus_b.req_wdata = d;
      end else begin
         bus_a.req_valid = v; bus_a.req_write = w; bus_a.req_addr = a; bus_a.req_wdata = d;
      end
   endtask

   task automatic drv_rr(input bit s, input logic r);
      if (s) bus_b.rsp_ready = r;
      else   bus_a.rsp_ready = r;
   endtask

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %h, want %h", name, act, exp);
      end
   endtask

   task automatic wait_accept(input bit s, output int n);
      logic pre;
      n = 0;
      do begin
         pre = rd_ready(s);
         @(posedge CLK); #1;
         n++;
      end while (!pre && n < 50);
      if (!pre) begin
         checks++; failures++;
         $display("FAIL accept_timeout: req_ready never seen in %0d cycles", n);
      end
   endtask

   task automatic wait_rsp(input bit s, output int lat);
      lat = 1;
      while (!rd_rvalid(s) && lat < 40) begin
         @(posedge CLK); #1;
         lat++;
      end
      if (!rd_rvalid(s)) begin
         checks++; failures++;
         $display("FAIL rsp_timeout: rsp_valid never seen in %0d cycles", lat);
      end
   endtask

   task automatic finish_rsp(input bit s, input int stall, input logic [63:0] held);
      for (int i = 0; i < stall; i++) begin
         @(posedge CLK); #1;
         check("stall_vld", 64'(rd_rvalid(s)), 64'd1);
         check("stall_rdata", rd_rdata(s), held);
      end
      drv_rr(s, 1'b1);
      @(posedge CLK); #1;
      check("rsp_drop_vld", 64'(rd_rvalid(s)), 64'd0);
      check("rsp_drop_rdata", rd_rdata(s), 64'd0);
      check("rsp_drop_err", 64'(rd_err(s)), 64'd0);
   endtask

   task automatic do_req(input bit s, input logic w, input logic [63:0] a, input logic [63:0] d,
                         input int stall, output logic [63:0] r, output logic e, output int lat);
      int n;
      drv_rr(s, stall == 0);
      drv(s, 1'b1, w, a, d);
      wait_accept(s, n);
      drv(s, 1'b0, 1'b0, 64'd0, 64'd0);
      wait_rsp(s, lat);
      r = rd_rdata(s);
      e = rd_err(s);
      finish_rsp(s, stall, r);
   endtask

   initial begin
      logic [63:0] r, v, a, exp_r;
      logic        e, exp_e, w;
      int          lat, n, k, last, cls, stall;

      drv(0, 1'b0, 1'b0, 64'd0, 64'd0);
      drv(1, 1'b0, 1'b0, 64'd0, 64'd0);
      drv_rr(0, 1'b1);
      drv_rr(1, 1'b1);
      rst_a = 1'b0;
      rst_b = 1'b0;

      // Reset state
      for (int i = 0; i < 3; i++) begin
         @(posedge CLK); #1;
         for (int s = 0; s < 2; s++) begin
            check($sformatf("rst%0d_ready", s), 64'(rd_ready(s[0])), 64'd0);
            check($sformatf("rst%0d_vld", s), 64'(rd_rvalid(s[0])), 64'd0);
            check($sformatf("rst%0d_rdata", s), rd_rdata(s[0]), 64'd0);
            check($sformatf("rst%0d_err", s), 64'(rd_err(s[0])), 64'd0);
         end
      end
      rst_a = 1'b1;
      rst_b = 1'b1;
      @(posedge CLK); #1;
      check("post_rst_ready_a", 64'(bus_a.req_ready), 64'd1);
      check("post_rst_ready_b", 64'(bus_b.req_ready), 64'd1);

      // Fill every entry so all later loads have known contents.
      for (int i = 0; i < 256; i++) begin
         v = (i == 0) ? 64'h0123_4567_89AB_CDEF : (i == 4) ? 64'd0 : {$urandom, $urandom};
         model_access(1'b1, 64'(i) * 64'd8, v, exp_e, exp_r);
         do_req(0, 1'b1, 64'(i) * 64'd8, v, 0, r, e, lat);
         check("fill_err", 64'(e), 64'(exp_e));
         check("fill_rdata", r, exp_r);
         check("fill_lat", 64'(lat), 64'd3);
      end

      vt[0]  = '{1'b1, 64'h10, 64'hDEAD_BEEF_CAFE_F00D, 1'b0, 64'd0};
      vt[1]  = '{1'b0, 64'h10, 64'd0, 1'b0, 64'hDEAD_BEEF_CAFE_F00D};
      vt[2]  = '{1'b0, 64'h13, 64'd0, 1'b1, 64'd0};
      vt[3]  = '{1'b1, 64'h800, 64'hBAD, 1'b1, 64'd0};
      vt[4]  = '{1'b0, 64'h0, 64'd0, 1'b0, 64'h0123_4567_89AB_CDEF};
      vt[5]  = '{1'b1, 64'h7F8, 64'hA5A5_A5A5_5A5A_5A5A, 1'b0, 64'd0};
      vt[6]  = '{1'b0, 64'h7F8, 64'd0, 1'b0, 64'hA5A5_A5A5_5A5A_5A5A};
      vt[7]  = '{1'b0, 64'h7FC, 64'd0, 1'b1, 64'd0};
      vt[8]  = '{1'b1, 64'h8000_0000_0000_0000, 64'd1, 1'b1, 64'd0};
      vt[9]  = '{1'b0, 64'hFFFF_FFFF_FFFF_FFF8, 64'd0, 1'b1, 64'd0};
      vt[10] = '{1'b0, 64'h0, 64'd0, 1'b0, 64'h0123_4567_89AB_CDEF};

      for (int i = 0; i < 11; i++) begin
         model_access(vt[i].w, vt[i].addr, vt[i].wdata, exp_e, exp_r);
         do_req(0, vt[i].w, vt[i].addr, vt[i].wdata, 0, r, e, lat);
         check($sformatf("vec%0d_err", i), 64'(e), 64'(vt[i].err));
         check($sformatf("vec%0d_rdata", i), r, vt[i].rdata);
         check($sformatf("vec%0d_lat", i), 64'(lat), 64'd3);
      end

      // Backpressure on a load of 0x10 while a new request is pending.
      drv_rr(0, 1'b0);
      drv(0, 1'b1, 1'b0, 64'h10, 64'd0);
      wait_accept(0, n);
      drv(0, 1'b1, 1'b0, 64'h0, 64'd0);
      wait_rsp(0, lat);
      check("bp_lat", 64'(lat), 64'd3);
      for (int i = 0; i < 5; i++) begin
         @(posedge CLK); #1;
         check("bp_vld", 64'(bus_a.rsp_valid), 64'd1);
         check("bp_rdata", bus_a.rsp_rdata, 64'hDEAD_BEEF_CAFE_F00D);
         check("bp_req_ready", 64'(bus_a.req_ready), 64'd0);
      end
      drv_rr(0, 1'b1);
      @(posedge CLK); #1;
      check("bp_release_vld", 64'(bus_a.rsp_valid), 64'd0);
      check("bp_release_ready", 64'(bus_a.req_ready), 64'd1);
      wait_accept(0, n);
      check("bp_next_accept", 64'(n), 64'd1);
      drv(0, 1'b0, 1'b0, 64'd0, 64'd0);
      wait_rsp(0, lat);
      check("bp_next_rdata", bus_a.rsp_rdata, 64'h0123_4567_89AB_CDEF);
      finish_rsp(0, 0, 64'd0);

      // Reset while a store is in BUSY must drop the store.
      drv(0, 1'b1, 1'b1, 64'h20, 64'h1111);
      wait_accept(0, n);
      drv(0, 1'b0, 1'b0, 64'd0, 64'd0);
      @(posedge CLK); #1;
      rst_a = 1'b0;
      #1;
      check("midrst_ready", 64'(bus_a.req_ready), 64'd0);
      check("midrst_vld", 64'(bus_a.rsp_valid), 64'd0);
      @(posedge CLK); #1;
      @(posedge CLK); #1;
      rst_a = 1'b1;
      @(posedge CLK); #1;
      check("midrst_post_ready", 64'(bus_a.req_ready), 64'd1);
      do_req(0, 1'b0, 64'h20, 64'd0, 0, r, e, lat);
      check("midrst_rdata", r, 64'd0);
      check("midrst_err", 64'(e), 64'd0);

      // Randomized traffic against the reference model.
      for (int i = 0; i < 200; i++) begin
         cls   = $urandom_range(0, 9);
         stall = $urandom_range(0, 3);
         w     = 1'($urandom_range(0, 1));
         v     = {$urandom, $urandom};
         if (cls <= 6)      a = 64'($urandom_range(0, 255)) * 64'd8;
         else if (cls == 7) a = 64'($urandom_range(0, 255)) * 64'd8 + 64'($urandom_range(1, 7));
         else if (cls == 8) a = 64'd2048 + 64'($urandom_range(0, 4095)) * 64'd8;
         else               a = {1'b1, 63'({$urandom, $urandom})};
         model_access(w, a, v, exp_e, exp_r);
         do_req(0, w, a, v, stall, r, e, lat);
         check($sformatf("rnd%0d_err", i), 64'(e), 64'(exp_e));
         check($sformatf("rnd%0d_rdata", i), r, exp_r);
         check($sformatf("rnd%0d_lat", i), 64'(lat), 64'd3);
      end

      // LATENCY=1 instance: fill four entries, then back-to-back loads.
      for (int i = 0; i < 4; i++) begin
         bvals[i] = {32'hB0B0_0000 + 32'(i), $urandom};
         do_req(1, 1'b1, 64'(i) * 64'd8, bvals[i], 0, r, e, lat);
         check("b_fill_lat", 64'(lat), 64'd1);
         check("b_fill_err", 64'(e), 64'd0);
      end
      k = 0;
      last = 0;
      drv_rr(1, 1'b1);
      drv(1, 1'b1, 1'b0, 64'd0, 64'd0);
      for (int cyc = 1; cyc <= 40 && k < 4; cyc++) begin
         logic pre;
         pre = bus_b.req_ready;
         @(posedge CLK); #1;
         if (pre) begin
            check($sformatf("b2b%0d_vld", k), 64'(bus_b.rsp_valid), 64'd1);
            check($sformatf("b2b%0d_rdata", k), bus_b.rsp_rdata, bvals[k]);
            check($sformatf("b2b%0d_err", k), 64'(bus_b.rsp_err), 64'd0);
            if (k > 0) check($sformatf("b2b%0d_gap", k), 64'(cyc - last), 64'd2);
            last = cyc;
            k++;
            if (k < 4) drv(1, 1'b1, 1'b0, 64'(k) * 64'd8, 64'd0);
            else       drv(1, 1'b0, 1'b0, 64'd0, 64'd0);
         end
      end
      if (k < 4) begin
         checks++; failures++;
         $display("FAIL b2b_timeout: only %0d of 4 loads accepted", k);
      end
      @(posedge CLK); #1;
      check("b2b_end_vld", 64'(bus_b.rsp_valid), 64'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
